acc_result_fifo: RTL

// - Drain buffer directly downstream of the ACC stage: captures finished partial sums from
//   the ACC DataOut/DataOutValid/DataOutRdy handshake and holds them for readout by the

---
 rtl/acc_result_fifo.sv | 135 +++++++++++++
 1 files changed

// File: rtl/acc_result_fifo.sv
// Drain buffer behind the ACC stage: a first-word-fall-through FIFO holding finished results
// for custom-instruction readout. Optional build macro: RESULT_RELU_EN (negative results stored as 0).
module acc_result_fifo #(
   parameter int DataWidth   = 32,
   parameter int BufferWidth = 3,
   parameter int BufferSize  = 8,
   parameter int PopCntWidth = 16
) (
   input  logic                   clk,
   input  logic                   aclr_n,
   input  logic                   clk_en,
   input  logic                   sclr,
   input  logic                   DataInValid,
   output logic                   DataInRdy,
   input  logic [DataWidth-1:0]   DataIn,
   output logic                   DataOutValid,
   input  logic                   DataOutRdy,
   output logic [DataWidth-1:0]   DataOut,
   output logic [BufferWidth:0]   Count,
   output logic [PopCntWidth-1:0] PopCount
);

   localparam logic [BufferWidth:0]   FullCount = (BufferWidth+1)'(BufferSize);
   localparam logic [BufferWidth:0]   CountOne  = (BufferWidth+1)'(1);
   localparam logic [BufferWidth-1:0] PtrOne    = BufferWidth'(1);
   localparam logic [PopCntWidth-1:0] PopOne    = PopCntWidth'(1);

   logic [DataWidth-1:0]   mem_r [BufferSize];
   logic [BufferWidth-1:0] wrPtr_r;
   logic [BufferWidth-1:0] rdPtr_r;
   logic [BufferWidth:0]   count_r;
   logic [PopCntWidth-1:0] popCount_r;
   logic                   inRdy_r;
   logic                   outValid_r;
   logic [DataWidth-1:0]   dataOut_r;

   logic                   push_s;
   logic                   pop_s;
   logic [DataWidth-1:0]   wordIn_s;
   logic [BufferWidth-1:0] nextWrPtr_s;
   logic [BufferWidth-1:0] nextRdPtr_s;
   logic [BufferWidth:0]   nextCount_s;
   logic [DataWidth-1:0]   nextHead_s;

   function automatic logic [DataWidth-1:0] storeWord(input logic [DataWidth-1:0] w);
`ifdef RESULT_RELU_EN
      if (w[DataWidth-1]) begin
         storeWord = '0;
      end else begin
         storeWord = w;
      end
`else
      storeWord = w;
`endif
   endfunction

   // Handshake qualification and next-state computation.
   always_comb begin
      push_s      = clk_en & DataInValid & inRdy_r;
      pop_s       = clk_en & outValid_r & DataOutRdy;
      wordIn_s    = storeWord(DataIn);
      nextWrPtr_s = wrPtr_r;
      nextRdPtr_s = rdPtr_r;
      nextCount_s = count_r;
      nextHead_s  = '0;
      if (push_s) begin
         nextWrPtr_s = wrPtr_r + PtrOne;
      end else begin
         nextWrPtr_s = wrPtr_r;
      end
      if (pop_s) begin
         nextRdPtr_s = rdPtr_r + PtrOne;
      end else begin
         nextRdPtr_s = rdPtr_r;
      end
      case ({push_s, pop_s})
         2'b10:   nextCount_s = count_r + CountOne;
         2'b01:   nextCount_s = count_r - CountOne;
         default: nextCount_s = count_r;
      endcase
      // The word being written this cycle becomes the head when it lands on the next read slot.
      if (nextCount_s == '0) begin
         nextHead_s = '0;
      end else if (push_s && (nextRdPtr_s == wrPtr_r)) begin
         nextHead_s = wordIn_s;
      end else begin
         nextHead_s = mem_r[nextRdPtr_s];
      end
   end

   // Storage array; deliberately not reset, contents are tracked by pointers and count.
   always_ff @(posedge clk) begin
      if (push_s && !sclr) begin
         mem_r[wrPtr_r] <= wordIn_s;
      end
   end

   // Pointers, counters and registered handshake outputs.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         wrPtr_r    <= '0;
         rdPtr_r    <= '0;
         count_r    <= '0;
         popCount_r <= '0;
         inRdy_r    <= 1'b1;
         outValid_r <= 1'b0;
         dataOut_r  <= '0;
      end else if (clk_en) begin
         if (sclr) begin
            wrPtr_r    <= '0;
            rdPtr_r    <= '0;
            count_r    <= '0;
            popCount_r <= '0;
            inRdy_r    <= 1'b1;
            outValid_r <= 1'b0;
            dataOut_r  <= '0;
         end else begin
            wrPtr_r    <= nextWrPtr_s;
            rdPtr_r    <= nextRdPtr_s;
            count_r    <= nextCount_s;
            popCount_r <= pop_s ? popCount_r + PopOne : popCount_r;
            inRdy_r    <= (nextCount_s != FullCount);
            outValid_r <= (nextCount_s != '0);
            dataOut_r  <= nextHead_s;
         end
      end
   end

   assign DataInRdy    = inRdy_r;
   assign DataOutValid = outValid_r;
   assign DataOut      = dataOut_r;
   assign Count        = count_r;
   assign PopCount     = popCount_r;

endmodule
